// File: rtl/stream_mux.sv
// stream_mux: N-input valid/ready stream multiplexer with a registered output
// stage. A channel is picked either by an external index (select mode) or by
// round-robin arbitration over all requesting inputs, and every output word
// carries the index of the channel that supplied it.
module stream_mux #(
    parameter int DATA_W = 32,
    parameter int NUM_IN = 3,
    parameter int SEL_W  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    input  logic [NUM_IN-1:0]        in_valid,
    output logic [NUM_IN-1:0]        in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SEL_W-1:0]         out_src,
    output logic                     err_sel,
    output logic [15:0]              xfer_cnt
);

    typedef enum logic {
        MODE_SELECT = 1'b0,
        MODE_RROBIN = 1'b1
    } mode_e;

    mode_e              modeSel;

    logic [DATA_W-1:0]  outData_q,   outData_d;
    logic [SEL_W-1:0]   outSrc_q,    outSrc_d;
    logic               outValid_q,  outValid_d;
    logic               errSel_q,    errSel_d;
    logic [15:0]        xferCnt_q,   xferCnt_d;
    logic [SEL_W-1:0]   lastGrant_q, lastGrant_d;

    logic               loadEn;
    logic               selInRange;
    logic               selErr;
    logic               rrValid;
    logic [SEL_W-1:0]   rrIdx;
    logic               grantValid;
    logic [SEL_W-1:0]   grantIdx;

    assign modeSel = mode_e'(mode);

    // The output register may accept a new word when it is empty or being
    // drained this cycle; nothing is offered to the inputs while in reset.
    assign loadEn     = rst_n && (!outValid_q || out_ready);
    assign selInRange = (int'(sel) < NUM_IN);

    // Round-robin search starting just after the last round-robin winner.
    always_comb begin
        rrValid = 1'b0;
        rrIdx   = '0;
        for (int off = 1; off <= NUM_IN; off++) begin
            if (!rrValid && in_valid[(int'(lastGrant_q) + off) % NUM_IN]) begin
                rrValid = 1'b1;
                rrIdx   = SEL_W'((int'(lastGrant_q) + off) % NUM_IN);
            end
        end
    end

    // Grant decision for the current cycle, including the bad-select flag.
    always_comb begin
        grantValid = 1'b0;
        grantIdx   = '0;
        selErr     = 1'b0;
        if (loadEn) begin
            if (modeSel == MODE_SELECT) begin
                if (!selInRange) begin
                    selErr = 1'b1;
                end else if (in_valid[sel]) begin
                    grantValid = 1'b1;
                    grantIdx   = sel;
                end
            end else begin
                grantValid = rrValid;
                grantIdx   = rrIdx;
            end
        end
    end

    // One-hot ready towards the granted channel only.
    always_comb begin
        in_ready = '0;
        if (grantValid) begin
            in_ready[grantIdx] = 1'b1;
        end
    end

    // Next state of the output stage, transfer counter and arbiter pointer.
    always_comb begin
        outData_d   = outData_q;
        outSrc_d    = outSrc_q;
        outValid_d  = outValid_q;
        lastGrant_d = lastGrant_q;
        errSel_d    = selErr;
        xferCnt_d   = xferCnt_q;

        if (outValid_q && out_ready) begin
            xferCnt_d = xferCnt_q + 16'd1;
        end

        if (loadEn) begin
            if (grantValid) begin
                outData_d  = in_data[int'(grantIdx) * DATA_W +: DATA_W];
                outSrc_d   = grantIdx;
                outValid_d = 1'b1;
                if (modeSel == MODE_RROBIN) begin
                    lastGrant_d = grantIdx;
                end
            end else begin
                outValid_d = 1'b0;
            end
        end
    end

    // State registers; the pointer resets to the last channel so channel 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outData_q   <= '0;
            outSrc_q    <= '0;
            outValid_q  <= 1'b0;
            errSel_q    <= 1'b0;
            xferCnt_q   <= '0;
            lastGrant_q <= SEL_W'(NUM_IN - 1);
        end else begin
            outData_q   <= outData_d;
            outSrc_q    <= outSrc_d;
            outValid_q  <= outValid_d;
            errSel_q    <= errSel_d;
            xferCnt_q   <= xferCnt_d;
            lastGrant_q <= lastGrant_d;
        end
    end

    assign out_data  = outData_q;
    assign out_src   = outSrc_q;
    assign out_valid = outValid_q;
    assign err_sel   = errSel_q;
    assign xfer_cnt  = xferCnt_q;

endmodule

// File: tb/tb_stream_mux.sv
// Testbench for stream_mux: randomized and directed stimulus, a queue-based
// scoreboard fed by a behavioural model, and an independent output monitor.
module tb_stream_mux;

    localparam int DATA_W = 32;
    localparam int NUM_IN = 3;
    localparam int SEL_W  = 2;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     mode;
    logic [SEL_W-1:0]         sel;
    logic [NUM_IN*DATA_W-1:0] in_data;
    logic [NUM_IN-1:0]        in_valid;
    logic [NUM_IN-1:0]        in_ready;
    logic [DATA_W-1:0]        out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [SEL_W-1:0]         out_src;
    logic                     err_sel;
    logic [15:0]              xfer_cnt;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [SEL_W-1:0]  src;
    } word_t;

    word_t expQ[$];
    int    checks = 0;
    int    errors = 0;

    bit    mOcc;
    int    mLast;
    int    mCnt;
    bit    mErr;

    stream_mux #(
        .DATA_W(DATA_W),
        .NUM_IN(NUM_IN),
        .SEL_W (SEL_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (mode),
        .sel      (sel),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_src  (out_src),
        .err_sel  (err_sel),
        .xfer_cnt (xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic expectEq(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    function automatic logic [NUM_IN*DATA_W-1:0] rndData();
        logic [NUM_IN*DATA_W-1:0] d;
        for (int k = 0; k < NUM_IN; k++) begin
            d[k*DATA_W +: DATA_W] = $urandom;
        end
        return d;
    endfunction

    task automatic resetModel();
        mOcc  = 1'b0;
        mLast = NUM_IN - 1;
        mCnt  = 0;
        mErr  = 1'b0;
        expQ.delete();
    endtask

    task automatic applyStimulus(input int m, input int s, input int v, input int r,
                                 input logic [NUM_IN*DATA_W-1:0] d);
        mode      = m[0];
        sel       = SEL_W'(s);
        in_valid  = NUM_IN'(v);
        out_ready = r[0];
        in_data   = d;
    endtask

    // Compare DUT flow-control outputs with the model, then advance the model
    // by what happens at the coming rising edge.
    task automatic checkOutput();
        int                g;
        bit                load;
        logic [NUM_IN-1:0] wantReady;
        word_t             w;

        g    = -1;
        load = !mOcc || out_ready;
        if (rst_n && load) begin
            if (mode == 1'b0) begin
                if (int'(sel) < NUM_IN && in_valid[sel]) g = int'(sel);
            end else begin
                for (int k = 1; k <= NUM_IN; k++) begin
                    if (in_valid[(mLast + k) % NUM_IN]) begin
                        g = (mLast + k) % NUM_IN;
                        break;
                    end
                end
            end
        end
        wantReady = '0;
        if (g >= 0) wantReady[g] = 1'b1;

        expectEq("in_ready",  in_ready,  wantReady);
        expectEq("out_valid", out_valid, mOcc);
        expectEq("err_sel",   err_sel,   mErr);
        expectEq("xfer_cnt",  xfer_cnt,  mCnt);

        if (rst_n) begin
            if (mOcc && out_ready) mCnt = (mCnt + 1) % 65536;
            mErr = (mode == 1'b0) && load && (int'(sel) >= NUM_IN);
            if (load) begin
                if (g >= 0) begin
                    w.data = in_data[g*DATA_W +: DATA_W];
                    w.src  = SEL_W'(g);
                    expQ.push_back(w);
                    mOcc = 1'b1;
                    if (mode == 1'b1) mLast = g;
                end else begin
                    mOcc = 1'b0;
                end
            end
        end
    endtask

    task automatic finishCycle();
        checkOutput();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input int m, input int s, input int v, input int r,
                        input logic [NUM_IN*DATA_W-1:0] d);
        applyStimulus(m, s, v, r, d);
        @(negedge clk);
        finishCycle();
    endtask

    // Output monitor: whenever a word is presented it must be the oldest
    // accepted word; it is retired when the consumer takes it.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (expQ.size() == 0) begin
                    expectEq("unexpected word", {31'd0, out_valid}, 64'd0);
                end else begin
                    expectEq("out_data", out_data, expQ[0].data);
                    expectEq("out_src",  out_src,  expQ[0].src);
                    if (out_ready) void'(expQ.pop_front());
                end
            end
        end
    end

    initial begin
        logic [NUM_IN*DATA_W-1:0] d;
        int                       guard;

        rst_n = 1'b0;
        applyStimulus(0, 0, 0, 0, '0);
        resetModel();
        @(posedge clk);
        #1;

        // Reset held with random inputs.
        for (int i = 0; i < 3; i++) begin
            applyStimulus($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 7),
                          $urandom_range(0, 1), rndData());
            @(negedge clk);
            expectEq("reset out_data", out_data, 0);
            expectEq("reset out_src",  out_src,  0);
            expectEq("reset in_ready", in_ready, 0);
            finishCycle();
        end
        rst_n = 1'b1;

        // First round-robin grant after reset goes to channel 0.
        applyStimulus(1, 0, 7, 1, rndData());
        @(negedge clk);
        expectEq("rr first grant", in_ready, 3'b001);
        finishCycle();

        // Select mode picks channel 2.
        d = rndData();
        d[2*DATA_W +: DATA_W] = 32'hDEADBEEF;
        applyStimulus(0, 2, 7, 1, d);
        @(negedge clk);
        expectEq("sel2 in_ready", in_ready, 3'b100);
        finishCycle();
        applyStimulus(0, 2, 0, 1, rndData());
        @(negedge clk);
        expectEq("sel2 out_data", out_data, 32'hDEADBEEF);
        expectEq("sel2 out_src",  out_src,  2);
        finishCycle();

        // Out-of-range select.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 3, 7, 1, rndData());
            @(negedge clk);
            expectEq("bad sel in_ready", in_ready, 0);
            if (i > 0) begin
                expectEq("bad sel err_sel",   err_sel,   1);
                expectEq("bad sel out_valid", out_valid, 0);
            end
            finishCycle();
        end
        step(0, 0, 0, 1, rndData());

        // Round-robin fairness from a fresh reset.
        rst_n = 1'b0;
        resetModel();
        step(1, 0, 7, 1, rndData());
        rst_n = 1'b1;
        for (int k = 0; k < 9; k++) begin
            applyStimulus(1, 0, 7, 1, rndData());
            @(negedge clk);
            if (k >= 1 && k <= 7) expectEq("rr sequence", out_src, (k - 1) % NUM_IN);
            if (k == 8) expectEq("rr xfer_cnt", xfer_cnt, 7);
            finishCycle();
        end

        // Back-pressure hold, then drain and reload in the same cycle.
        step(0, 0, 0, 1, rndData());
        d = rndData();
        d[0 +: DATA_W] = 32'h11;
        step(0, 0, 1, 0, d);
        for (int i = 0; i < 4; i++) begin
            d = rndData();
            d[0 +: DATA_W] = 32'h99;
            applyStimulus(0, 0, 1, 0, d);
            @(negedge clk);
            expectEq("bp out_data", out_data, 32'h11);
            expectEq("bp in_ready", in_ready, 0);
            finishCycle();
        end
        d = rndData();
        d[0 +: DATA_W] = 32'h22;
        applyStimulus(0, 0, 1, 1, d);
        @(negedge clk);
        expectEq("bp release in_ready", in_ready, 3'b001);
        finishCycle();
        applyStimulus(0, 0, 0, 0, rndData());
        @(negedge clk);
        expectEq("bp reload out_data",  out_data,  32'h22);
        expectEq("bp reload out_valid", out_valid, 1);
        finishCycle();

        // Randomized traffic with mode/sel changes and random back-pressure.
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 7),
                 ($urandom_range(0, 3) != 0) ? 1 : 0, rndData());
        end

        // Asynchronous reset between edges while a word is held.
        step(1, 0, 7, 0, rndData());
        step(1, 0, 7, 0, rndData());
        applyStimulus(1, 0, 7, 1, rndData());
        #2;
        rst_n = 1'b0;
        resetModel();
        #1;
        expectEq("async rst out_valid", out_valid, 0);
        expectEq("async rst in_ready",  in_ready,  0);
        expectEq("async rst out_data",  out_data,  0);
        @(negedge clk);
        finishCycle();
        rst_n = 1'b1;

        // Run the transfer counter up to its wrap point.
        guard = 0;
        while (mCnt != 65535 && guard < 70000) begin
            step(1, 0, 7, 1, rndData());
            guard++;
        end
        expectEq("wrap reached", (mCnt == 65535) ? 1 : 0, 1);
        applyStimulus(1, 0, 7, 1, rndData());
        @(negedge clk);
        expectEq("xfer_cnt max", xfer_cnt, 16'hFFFF);
        finishCycle();
        applyStimulus(1, 0, 7, 1, rndData());
        @(negedge clk);
        expectEq("xfer_cnt wrap", xfer_cnt, 16'h0000);
        finishCycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
